regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter_pkg.sv | 26 ++
 rtl/regfile_wb_arbiter_if.sv | 29 ++
 rtl/regfile_wb_arbiter_prio_arb.sv | 58 +++++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants, state encoding and request type for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned ADDR_W           = 6;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned NUM_REGS_DEF     = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef enum logic [0:0] {
        StClear = 1'b0,
        StRun   = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // x0 and out-of-range indices are accepted but never reach the register file.
    function automatic logic addr_writable(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       num_regs);
        return (addr != '0) && (32'(addr) < num_regs);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Two writeback requesters plus the register-file write port.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Requester / register-file side.
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/regfile_wb_arbiter_prio_arb.sv
// Two-way priority grant (A over B) with a starvation counter that forces B through.
module regfile_wb_arbiter_prio_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_run,
    input  logic i_clear_req,
    input  logic i_a_valid,
    input  logic i_b_valid,
    output logic o_a_ready,
    output logic o_b_ready
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_force_b;

    // Grant: starved B first, then A, then B; nothing while clearing or leaving RUN.
    always_comb begin
        o_a_ready = 1'b0;
        o_b_ready = 1'b0;
        w_force_b = i_b_valid && (r_starve_cnt == CNT_W'(STARVE_LIMIT));
        if (i_run && !i_clear_req) begin
            if (w_force_b) begin
                o_b_ready = 1'b1;
            end else if (i_a_valid) begin
                o_a_ready = 1'b1;
            end else if (i_b_valid) begin
                o_b_ready = 1'b1;
            end
        end
    end

    // Starvation counter next value: count B wait cycles, saturate, clear on B or on clear.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!i_run || i_clear_req) begin
            w_starve_nxt = '0;
        end else if (i_b_valid && o_b_ready) begin
            w_starve_nxt = '0;
        end else if (i_b_valid && (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            w_starve_nxt = r_starve_cnt + CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port sequencer: clears every register after reset or on request,
// then shares the registered write port between two writeback requesters.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REGS     = NUM_REGS_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_clear_req,
    output logic                 o_init_done,
    regfile_wb_arbiter_if.slave  wb
);

    wb_state_e         r_state;
    wb_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] w_clr_idx_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] w_waddr_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              w_a_ready;
    logic              w_b_ready;
    wb_req_t           w_sel;

    regfile_wb_arbiter_prio_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_run       (r_state == StRun),
        .i_clear_req (i_clear_req),
        .i_a_valid   (wb.a_valid),
        .i_b_valid   (wb.b_valid),
        .o_a_ready   (w_a_ready),
        .o_b_ready   (w_b_ready)
    );

    // Select the accepted transfer, if any (at most one side is ready).
    always_comb begin
        w_sel.valid = (wb.a_valid && w_a_ready) || (wb.b_valid && w_b_ready);
        w_sel.addr  = w_b_ready ? wb.b_addr : wb.a_addr;
        w_sel.data  = w_b_ready ? wb.b_data : wb.a_data;
    end

    // Clear walk / run state machine and next value of the registered write port.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_we_nxt      = 1'b0;
        w_waddr_nxt   = r_waddr;
        w_wdata_nxt   = r_wdata;
        case (r_state)
            StClear: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = r_clr_idx;
                w_wdata_nxt = '0;
                if (r_clr_idx == ADDR_W'(NUM_REGS - 1)) begin
                    w_state_nxt   = StRun;
                    w_clr_idx_nxt = '0;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
                end
            end
            StRun: begin
                if (i_clear_req) begin
                    w_state_nxt   = StClear;
                    w_clr_idx_nxt = '0;
                end else if (w_sel.valid) begin
                    w_we_nxt    = addr_writable(w_sel.addr, NUM_REGS);
                    w_waddr_nxt = w_sel.addr;
                    w_wdata_nxt = w_sel.data;
                end
            end
            default: begin
                w_state_nxt   = StClear;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    // State, clear index and write-port registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= StClear;
            r_clr_idx <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_we      <= w_we_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wdata   <= w_wdata_nxt;
        end
    end

    assign wb.a_ready  = w_a_ready;
    assign wb.b_ready  = w_b_ready;
    assign wb.rf_we    = r_we;
    assign wb.rf_waddr = r_waddr;
    assign wb.rf_wdata = r_wdata;
    assign o_init_done = (r_state == StRun);

endmodule
